// File: rtl/nibble_chk_pkg.sv
// Shared types and constants for the nibble pattern checker: FSM states,
// the two legal symbol codes and the legality test.
package nibble_chk_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [3:0] CODE_A = 4'b1001;
  localparam logic [3:0] CODE_B = 4'b0110;

  function automatic logic is_legal(input logic [3:0] code);
    return (code == CODE_A) || (code == CODE_B);
  endfunction

endpackage

// File: rtl/nibble_pattern_checker_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/nibble_pattern_checker.sv
// Alternating-symbol lock detector (SEARCH/SYNC/LOCKED) with a flywheel in LOCKED.
// Define NIBBLE_PATTERN_CHECKER_DISPLAY_EN for simulation lock/unlock/error messages.
module nibble_pattern_checker
  import nibble_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [3:0]       data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      sym_count
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

  chk_state_t state, state_nxt;
  logic [3:0] run, run_nxt;
  logic [3:0] miss, miss_nxt;
  logic [3:0] expected, expected_nxt;
  logic       err_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      run       <= '0;
      miss      <= '0;
      expected  <= CODE_A;
      err_pulse <= 1'b0;
      sym_count <= '0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      miss      <= miss_nxt;
      expected  <= expected_nxt;
      err_pulse <= err_evt;
      if (valid) begin
        sym_count <= sym_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    run_nxt      = run;
    miss_nxt     = miss;
    expected_nxt = expected;
    err_evt      = 1'b0;
    if (valid) begin
      unique case (state)
        SEARCH: begin
          if (is_legal(data)) begin
            expected_nxt = ~data;
            run_nxt      = 4'd1;
            state_nxt    = SYNC;
          end
        end
        SYNC: begin
          if (data == expected) begin
            run_nxt      = run + 4'd1;
            expected_nxt = ~data;
            if (run_nxt == LOCK_N) begin
              state_nxt = LOCKED;
            end
          end else if (is_legal(data)) begin
            run_nxt      = 4'd1;
            expected_nxt = ~data;
          end else begin
            run_nxt   = '0;
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: the expected phase advances regardless of the match result.
          expected_nxt = ~expected;
          if (data == expected) begin
            miss_nxt = '0;
          end else begin
            err_evt  = 1'b1;
            miss_nxt = miss + 4'd1;
            if (miss_nxt == UNLOCK_N) begin
              state_nxt = SEARCH;
              run_nxt   = '0;
              miss_nxt  = '0;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_evt),
    .count (err_count)
  );

`ifdef NIBBLE_PATTERN_CHECKER_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst && valid) begin
      if (state != LOCKED && state_nxt == LOCKED)
        $display("%0t nibble_pattern_checker: lock   state=%s data=%b", $time, state_nxt.name(), data);
      if (state == LOCKED && state_nxt != LOCKED)
        $display("%0t nibble_pattern_checker: unlock state=%s data=%b", $time, state_nxt.name(), data);
      if (err_evt)
        $display("%0t nibble_pattern_checker: error  state=%s data=%b", $time, state.name(), data);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_pattern_checker.sv
// Scoreboard bench for nibble_pattern_checker: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared one cycle later.
module tb_nibble_pattern_checker;
  import nibble_chk_pkg::*;

  logic        clk, rst, valid;
  logic [3:0]  data;
  logic        locked, err_pulse, locked2, err_pulse2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
  logic [15:0] sym_count, sym_count2;

  nibble_pattern_checker u_dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .sym_count(sym_count)
  );

  nibble_pattern_checker #(.ERR_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .valid(valid), .data(data),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .sym_count(sym_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err8;
    logic [1:0]  err2;
    logic [15:0] sym;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;

  // reference model: 0=SEARCH 1=SYNC 2=LOCKED
  int         m_state, m_run, m_miss, m_err8, m_err2, m_sym;
  logic [3:0] m_exp;
  logic       m_errp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_miss = 0; m_err8 = 0; m_err2 = 0; m_sym = 0;
    m_exp = 4'b1001; m_errp = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [3:0] d);
    m_errp = 1'b0;
    if (v) begin
      m_sym = (m_sym + 1) % 65536;
      case (m_state)
        0: if (d == 4'b1001 || d == 4'b0110) begin
             m_exp = ~d; m_run = 1; m_state = 1;
           end
        1: if (d == m_exp) begin
             m_run++; m_exp = ~d;
             if (m_run == 4) m_state = 2;
           end else if (d == 4'b1001 || d == 4'b0110) begin
             m_run = 1; m_exp = ~d;
           end else begin
             m_run = 0; m_state = 0;
           end
        default: begin
          if (d == m_exp) m_miss = 0;
          else begin
            m_errp = 1'b1;
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
            m_miss++;
            if (m_miss == 2) begin
              m_state = 0; m_run = 0; m_miss = 0;
            end
          end
          m_exp = ~m_exp;
        end
      endcase
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("locked",       32'(locked),     32'(e.locked));
      check("err_pulse",    32'(err_pulse),  32'(e.err_pulse));
      check("err_count",    32'(err_count),  32'(e.err8));
      check("sym_count",    32'(sym_count),  32'(e.sym));
      check("w2_locked",    32'(locked2),    32'(e.locked));
      check("w2_err_pulse", 32'(err_pulse2), 32'(e.err_pulse));
      check("w2_err_count", 32'(err_count2), 32'(e.err2));
      check("w2_sym_count", 32'(sym_count2), 32'(e.sym));
    end
  endtask

  task automatic send(input logic v, input logic [3:0] d);
    exp_t e;
    valid = v;
    data  = d;
    model_step(v, d);
    e.locked    = (m_state == 2);
    e.err_pulse = m_errp;
    e.err8      = 8'(m_err8);
    e.err2      = 2'(m_err2);
    e.sym       = 16'(m_sym);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic lock_seq();
    send(1'b1, 4'b1001);
    send(1'b1, 4'b0110);
    send(1'b1, 4'b1001);
    send(1'b1, 4'b0110);
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; data = 4'h0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // lock on four alternating symbols
    lock_seq();
    check("lock_after_4th", 32'(locked),    32'd1);
    check("lock_err_count", 32'(err_count), 32'd0);
    check("lock_sym_count", 32'(sym_count), 32'd4);

    // single miss, then a flywheel-phase match clears it
    send(1'b1, 4'b1001);
    send(1'b1, 4'b1001);
    check("miss1_err_pulse", 32'(err_pulse), 32'd1);
    check("miss1_err_count", 32'(err_count), 32'd1);
    send(1'b1, 4'b1001);
    check("miss1_pulse_gone", 32'(err_pulse), 32'd0);
    check("miss1_still_lock", 32'(locked),    32'd1);

    // two consecutive misses drop lock; the unlocking symbol counts as an error
    send(1'b1, 4'b1111);
    check("miss2a_locked", 32'(locked), 32'd1);
    send(1'b1, 4'b1111);
    check("miss2b_locked",    32'(locked),    32'd0);
    check("miss2b_err_pulse", 32'(err_pulse), 32'd1);
    check("miss2b_err_count", 32'(err_count), 32'd3);

    // illegal code in SYNC returns to SEARCH silently; idle cycles hold counters
    send(1'b1, 4'b1001);
    send(1'b1, 4'b0110);
    send(1'b1, 4'b1111);
    check("sync_abort_pulse", 32'(err_pulse), 32'd0);
    check("sync_abort_state", 32'(u_dut.state), 32'(SEARCH));
    for (int i = 0; i < 10; i++) send(1'b0, 4'($urandom_range(0, 15)));
    check("idle_sym_count", 32'(sym_count), 32'd12);
    check("idle_err_count", 32'(err_count), 32'd3);

    // asynchronous reset while locked, between clock edges
    lock_seq();
    send(1'b1, 4'b1001);
    rst = 1'b1;
    #1;
    check("arst_locked",    32'(locked),         32'd0);
    check("arst_err_pulse", 32'(err_pulse),      32'd0);
    check("arst_err_count", 32'(err_count),      32'd0);
    check("arst_sym_count", 32'(sym_count),      32'd0);
    check("arst_w2_err",    32'(err_count2),     32'd0);
    check("arst_state",     32'(u_dut.state),    32'(SEARCH));
    check("arst_expected",  32'(u_dut.expected), 32'(CODE_A));
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // five mismatches while locked, relocking after each unlock
    for (int i = 0; i < 5; i++) begin
      if (m_state != 2) lock_seq();
      send(1'b1, 4'b1111);
    end
    check("sat_w2_err_count", 32'(err_count2), 32'd3);
    check("sat_w8_err_count", 32'(err_count),  32'd5);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
